keystone_stream_adapter: RTL and testbench
==========================================

Name: keystone_stream_adapter

Overview:
- Parametrised front-end stage placed between the video AXI-Stream source and the keystone correction core.
- Synchronises to frames: discards beats until the first start-of-frame.
- Buffers the stream in a small FIFO and checks line length against a configured beat count.
- Holds a shadow copy of the 8 homography coefficients and the enable bit, and applies them atomically at an output-side frame boundary, so the core never changes coefficients mid-frame.

Parameters:
- DATA_W, 64, tdata width in bits.
- COEFF_W, 32, width of each homography coefficient (two's complement fixed point).
- COEFF_FRAC, 16, fractional bits of a coefficient; used for the identity reset value.
- NUM_COEFF, 8, coefficient count (H11,H12,H13,H21,H22,H23,H31,H32; H33 is implicitly 1).
- FIFO_DEPTH, 4, buffer depth in beats; must be a power of 2 and at least 2.
- LINE_CNT_W, 16, width of the beat-per-line counter.

Ports:
- clock  in  1  sole clock.
- reset  in  1  synchronous, active-high; also driven by software reset.
- clock_en  in  1  global stall; all state frozen while low.
- s_axis_tdata  in  DATA_W  input pixels.
- s_axis_tvalid  in  1  input valid.
- s_axis_tready  out  1  input ready.
- s_axis_tuser  in  1  start of frame (SOF).
- s_axis_tlast  in  1  end of line (EOL).
- m_axis_tdata  out  DATA_W  output pixels to core.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  core ready.
- m_axis_tuser  out  1  output SOF.
- m_axis_tlast  out  1  output EOL.
- cfg_coeff  in  NUM_COEFF*COEFF_W  live coefficient bus; H11 in the LSBs.
- cfg_enable  in  1  live keystone enable.
- cfg_commit  in  1  one-cycle pulse; stages cfg_coeff and cfg_enable.
- cfg_line_beats  in  LINE_CNT_W  expected beats per line.
- coeff_active  out  NUM_COEFF*COEFF_W  coefficients in force for the core.
- enable_active  out  1  enable in force for the core.
- coeff_update  out  1  one-cycle pulse when the active set changes.
- line_err  out  1  one-cycle pulse on a line-length mismatch.
- sof_err  out  1  one-cycle pulse on a SOF that arrives mid-line.

Behaviour:
- Reset values:
  - All outputs 0, except coeff_active, which resets to identity: H11 = H22 = 1<<COEFF_FRAC, all others 0.
  - enable_active = 0; FIFO empty; state SYNC; pending = 0; line counter = 0.
- clock_en = 0:
  - s_axis_tready and m_axis_tvalid are forced to 0.
  - No register updates; pulse outputs read 0.
- Input FSM, SYNC state:
  - s_axis_tready = 1.
  - Accepted beats with tuser = 0 are dropped and not written to the FIFO.
  - An accepted beat with tuser = 1 is written and moves the FSM to ACTIVE.
- Input FSM, ACTIVE state:
  - s_axis_tready = !fifo_full. There is no combinational path from m_axis_tready; no push occurs when full, even if a pop happens that cycle.
  - Every accepted beat is written.
  - Reset returns the FSM to SYNC from any state; FIFO contents are lost.
- Line check (ACTIVE only):
  - The counter increments on each accepted beat.
  - On an accepted tlast beat, if count+1 != cfg_line_beats, line_err pulses on the next cycle; the counter then clears.
  - On an accepted tuser beat with count != 0, sof_err pulses on the next cycle; the counter restarts at 1 and the beat is kept.
  - The counter saturates at all-ones.
- FIFO:
  - Registered, carries {tuser, tlast, tdata}.
  - A written beat appears on m_axis one cycle after acceptance at the earliest.
  - m_axis_tvalid = !empty; a pop happens when m_axis_tvalid && m_axis_tready.
  - Simultaneous push and pop when not full keeps the occupancy unchanged.
  - Pointers wrap modulo FIFO_DEPTH; occupancy is held in a log2(FIFO_DEPTH)+1-bit counter.
- Shadow registers:
  - cfg_commit loads staged_coeff/staged_enable and sets pending.
  - A later commit before apply overwrites the staged values (last wins).
- Apply:
  - On an output handshake of a beat with tuser = 1 while pending = 1: coeff_active <= staged_coeff, enable_active <= staged_enable, pending <= 0, and coeff_update pulses in the same cycle as the handshake.
  - If cfg_commit coincides with an apply, the new values are staged, pending stays 1, and they apply at the following SOF.
  - A commit issued after a SOF has been buffered but before it is popped applies to that frame.
- Arithmetic: no arithmetic on coefficients; they are passed bit-exact.

Optional Feature:
- KEYSTONE_ADAPTER_STATS_EN defined:
  - Adds outputs stat_frames, stat_line_errs, stat_sof_errs, each 32 bits.
  - stat_frames counts output SOF handshakes; the error counters count line_err and sof_err pulses.
  - All counters saturate at 0xFFFFFFFF and reset to 0.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package keystone_pkg:
  - coeff_t (logic signed [COEFF_W-1:0]).
  - Coefficient index enum H11_IDX..H32_IDX.
  - in_state_t {SYNC, ACTIVE}.
  - Function identity_coeffs() returning the reset bus.
- One sub-module: keystone_sync_fifo (parametrised DATA_W+2 wide, FIFO_DEPTH deep, full/empty/occupancy).
- FSM, line check and shadow logic live in the top module.

Test Plan:
- After reset, send 3 beats with tuser = 0, then a SOF beat with data 0xA5 -> first 3 beats dropped with tready = 1; first m_axis beat has tdata = 0xA5, tuser = 1; coeff_active equals identity (H11 = H22 = 0x00010000).
- cfg_line_beats = 4; send lines of 4, 3 and 5 beats -> line_err pulses after the 2nd and 3rd lines only; all 12 beats are emitted in order.
- Hold m_axis_tready = 0 and drive 6 beats with FIFO_DEPTH = 4 -> exactly 4 accepted, then s_axis_tready = 0; release -> beats 5 and 6 accepted, no loss or duplication.
- Commit H13 = 0x00050000 mid-frame -> coeff_active is unchanged until the next output SOF handshake; coeff_update pulses exactly on that cycle; a second commit in the same frame wins.
- SOF after 2 beats of a line -> sof_err pulses one cycle later; the beat is forwarded with tuser = 1 and line counting restarts.
- Hold clock_en = 0 for 5 cycles mid-frame, then assert reset mid-frame -> no state change while stalled; after reset, state is SYNC, FIFO empty and outputs at reset values.

Source files
------------

// File: rtl/keystone_pkg.sv
// Shared types and constants for the keystone stream adapter.
// Provides coefficient typing, the input FSM encoding and the identity coefficient bus.
package keystone_pkg;

    localparam int COEFF_W_DEF    = 32;
    localparam int COEFF_FRAC_DEF = 16;
    localparam int NUM_COEFF_DEF  = 8;
    localparam int IDENT_MAX_W    = 1024;

    typedef logic signed [COEFF_W_DEF-1:0] coeff_t;

    typedef enum logic [2:0] {
        H11_IDX,
        H12_IDX,
        H13_IDX,
        H21_IDX,
        H22_IDX,
        H23_IDX,
        H31_IDX,
        H32_IDX
    } coeff_idx_t;

    typedef enum logic {
        SYNC   = 1'b0,
        ACTIVE = 1'b1
    } in_state_t;

    // Identity homography on a wide bus; callers truncate to their own bus width.
    function automatic logic [IDENT_MAX_W-1:0] identity_coeffs(input int unsigned coeff_w,
                                                               input int unsigned frac);
        logic [IDENT_MAX_W-1:0] one;
        one = IDENT_MAX_W'(1);
        return (one << (int'(H11_IDX) * coeff_w + frac)) |
               (one << (int'(H22_IDX) * coeff_w + frac));
    endfunction

endpackage

// File: rtl/keystone_sync_fifo.sv
// Single-clock registered FIFO with occupancy counter; DEPTH must be a power of 2.
// Pushes while full and pops while empty are ignored.
module keystone_sync_fifo #(
    parameter int WIDTH = 66,
    parameter int DEPTH = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    push,
    input  logic [WIDTH-1:0]        push_data,
    input  logic                    pop,
    output logic [WIDTH-1:0]        pop_data,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  occupancy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (occupancy == LVL_W'(DEPTH));
    assign empty    = (occupancy == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   occupancy <= occupancy + 1'b1;
                2'b01:   occupancy <= occupancy - 1'b1;
                default: ;
            endcase
        end
    end

    // NOTE: storage has no reset; pointers and occupancy alone define which entries are valid.
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/keystone_stream_adapter.sv
// Frame-synchronising front end for the keystone core: FIFO buffering, line-length check and
// frame-atomic coefficient shadowing. Define KEYSTONE_ADAPTER_STATS_EN to add 32-bit stat counters.
module keystone_stream_adapter
    import keystone_pkg::*;
#(
    parameter int DATA_W     = 64,
    parameter int COEFF_W    = COEFF_W_DEF,
    parameter int COEFF_FRAC = COEFF_FRAC_DEF,
    parameter int NUM_COEFF  = NUM_COEFF_DEF,
    parameter int FIFO_DEPTH = 4,
    parameter int LINE_CNT_W = 16
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          clock_en,
    input  logic [DATA_W-1:0]             s_axis_tdata,
    input  logic                          s_axis_tvalid,
    output logic                          s_axis_tready,
    input  logic                          s_axis_tuser,
    input  logic                          s_axis_tlast,
    output logic [DATA_W-1:0]             m_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          m_axis_tuser,
    output logic                          m_axis_tlast,
    input  logic [NUM_COEFF*COEFF_W-1:0]  cfg_coeff,
    input  logic                          cfg_enable,
    input  logic                          cfg_commit,
    input  logic [LINE_CNT_W-1:0]         cfg_line_beats,
    output logic [NUM_COEFF*COEFF_W-1:0]  coeff_active,
    output logic                          enable_active,
    output logic                          coeff_update,
    output logic                          line_err,
    output logic                          sof_err
`ifdef KEYSTONE_ADAPTER_STATS_EN
    ,
    output logic [31:0]                   stat_frames,
    output logic [31:0]                   stat_line_errs,
    output logic [31:0]                   stat_sof_errs
`endif
);

    localparam int BUS_W = NUM_COEFF * COEFF_W;
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [BUS_W-1:0] IDENTITY = BUS_W'(identity_coeffs(COEFF_W, COEFF_FRAC));

    in_state_t             state_q;
    in_state_t             state_d;
    logic                  push;
    logic                  pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [LVL_W-1:0]      fifo_level;
    logic [DATA_W+1:0]     fifo_rdata;
    logic [DATA_W-1:0]     fifo_data;
    logic                  fifo_user;
    logic                  fifo_last;

    logic [LINE_CNT_W-1:0] line_cnt_q;
    logic [LINE_CNT_W-1:0] line_base;
    logic [LINE_CNT_W-1:0] line_inc;
    logic                  sof_mid;
    logic                  line_err_q;
    logic                  sof_err_q;

    logic [BUS_W-1:0]      staged_coeff;
    logic                  staged_enable;
    logic                  pending;
    logic                  apply;

    keystone_sync_fifo #(
        .WIDTH (DATA_W + 2),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data ({s_axis_tuser, s_axis_tlast, s_axis_tdata}),
        .pop       (pop),
        .pop_data  (fifo_rdata),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .occupancy (fifo_level)
    );

    assign {fifo_user, fifo_last, fifo_data} = fifo_rdata;

    fifo_level_bounded: assert property (@(posedge clock) disable iff (reset)
        fifo_level <= LVL_W'(FIFO_DEPTH));

    always_ff @(posedge clock) begin
        if (reset)         state_q <= SYNC;
        else if (clock_en) state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (state_q == SYNC && push) state_d = ACTIVE;
    end

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        s_axis_tready = 1'b0;
        push          = 1'b0;
        if (clock_en) begin
            case (state_q)
                SYNC: begin
                    s_axis_tready = 1'b1;
                    push          = s_axis_tvalid && s_axis_tuser;
                end
                ACTIVE: begin
                    s_axis_tready = !fifo_full;
                    push          = s_axis_tvalid && !fifo_full;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        m_axis_tvalid = clock_en && !fifo_empty;
        pop           = m_axis_tvalid && m_axis_tready;
        m_axis_tdata  = m_axis_tvalid ? fifo_data : '0;
        m_axis_tuser  = m_axis_tvalid && fifo_user;
        m_axis_tlast  = m_axis_tvalid && fifo_last;
        apply         = pop && fifo_user && pending;
        coeff_update  = apply;
        line_err      = clock_en && line_err_q;
        sof_err       = clock_en && sof_err_q;
    end

    // A SOF arriving mid-line restarts the count so the SOF beat itself becomes beat 1.
    always_comb begin
        sof_mid   = s_axis_tuser && (line_cnt_q != '0);
        line_base = sof_mid ? '0 : line_cnt_q;
        line_inc  = (&line_base) ? line_base : line_base + 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            line_cnt_q <= '0;
            line_err_q <= 1'b0;
            sof_err_q  <= 1'b0;
        end else if (clock_en) begin
            line_err_q <= push && s_axis_tlast && (line_inc != cfg_line_beats);
            sof_err_q  <= push && sof_mid;
            if (push) line_cnt_q <= s_axis_tlast ? '0 : line_inc;
        end
    end

    // Apply reads the old staged set, so a commit landing on the apply cycle waits for the next SOF.
    always_ff @(posedge clock) begin
        if (reset) begin
            staged_coeff  <= IDENTITY;
            staged_enable <= 1'b0;
            pending       <= 1'b0;
            coeff_active  <= IDENTITY;
            enable_active <= 1'b0;
        end else if (clock_en) begin
            if (cfg_commit) begin
                staged_coeff  <= cfg_coeff;
                staged_enable <= cfg_enable;
            end
            if (apply) begin
                coeff_active  <= staged_coeff;
                enable_active <= staged_enable;
            end
            pending <= cfg_commit || (pending && !apply);
        end
    end

`ifdef KEYSTONE_ADAPTER_STATS_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            stat_frames    <= '0;
            stat_line_errs <= '0;
            stat_sof_errs  <= '0;
        end else if (clock_en) begin
            if (pop && fifo_user && stat_frames != '1) stat_frames <= stat_frames + 1'b1;
            if (line_err_q && stat_line_errs != '1)    stat_line_errs <= stat_line_errs + 1'b1;
            if (sof_err_q && stat_sof_errs != '1)      stat_sof_errs <= stat_sof_errs + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_keystone_stream_adapter.sv
// Self-checking bench for keystone_stream_adapter: queue-based reference model compared every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_keystone_stream_adapter;
    import keystone_pkg::*;

    localparam logic [255:0] IDENT = {32'h0, 32'h0, 32'h0, 32'h00010000,
                                      32'h0, 32'h0, 32'h0, 32'h00010000};

    typedef struct packed {
        logic        u;
        logic        l;
        logic [63:0] d;
    } beat_t;

    logic         clock = 1'b0;
    logic         reset;
    logic         clock_en;
    logic [63:0]  s_axis_tdata;
    logic         s_axis_tvalid;
    logic         s_axis_tready;
    logic         s_axis_tuser;
    logic         s_axis_tlast;
    logic [63:0]  m_axis_tdata;
    logic         m_axis_tvalid;
    logic         m_axis_tready;
    logic         m_axis_tuser;
    logic         m_axis_tlast;
    logic [255:0] cfg_coeff;
    logic         cfg_enable;
    logic         cfg_commit;
    logic [15:0]  cfg_line_beats;
    logic [255:0] coeff_active;
    logic         enable_active;
    logic         coeff_update;
    logic         line_err;
    logic         sof_err;

    int n_checks = 0;
    int n_fail   = 0;
    int le_seen  = 0;
    int se_seen  = 0;
    int upd_seen = 0;
    int in_acc   = 0;
    int out_cnt  = 0;

    keystone_stream_adapter dut (
        .clock          (clock),
        .reset          (reset),
        .clock_en       (clock_en),
        .s_axis_tdata   (s_axis_tdata),
        .s_axis_tvalid  (s_axis_tvalid),
        .s_axis_tready  (s_axis_tready),
        .s_axis_tuser   (s_axis_tuser),
        .s_axis_tlast   (s_axis_tlast),
        .m_axis_tdata   (m_axis_tdata),
        .m_axis_tvalid  (m_axis_tvalid),
        .m_axis_tready  (m_axis_tready),
        .m_axis_tuser   (m_axis_tuser),
        .m_axis_tlast   (m_axis_tlast),
        .cfg_coeff      (cfg_coeff),
        .cfg_enable     (cfg_enable),
        .cfg_commit     (cfg_commit),
        .cfg_line_beats (cfg_line_beats),
        .coeff_active   (coeff_active),
        .enable_active  (enable_active),
        .coeff_update   (coeff_update),
        .line_err       (line_err),
        .sof_err        (sof_err)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Offers one beat from the next falling edge and returns just after the accepting edge.
    task automatic send(input logic [63:0] d, input logic u, input logic l);
        int waited;
        waited = 0;
        @(negedge clock);
        s_axis_tdata  = d;
        s_axis_tuser  = u;
        s_axis_tlast  = l;
        s_axis_tvalid = 1'b1;
        #1;
        while (!s_axis_tready && waited < 200) begin
            @(negedge clock);
            #1;
            waited++;
        end
        if (!s_axis_tready) check("send_tready_timeout", s_axis_tready, 1'b1);
        @(posedge clock);
        #1;
        s_axis_tvalid = 1'b0;
        s_axis_tuser  = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic commit(input logic [31:0] h13, input logic en);
        @(negedge clock);
        cfg_coeff         = IDENT;
        cfg_coeff[95:64]  = h13;
        cfg_enable        = en;
        cfg_commit        = 1'b1;
        @(negedge clock);
        cfg_commit        = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Reference model: frame sync flag, beat queue, integer line count and shadow/active sets.
    initial begin : model
        beat_t        q[$];
        bit           synced;
        int           line_cnt;
        bit           pend_le, pend_se, pending, st_en, act_en;
        logic [255:0] staged, active;
        bit           e_tready, e_mvalid, e_update, do_pop, do_write;
        synced = 0; line_cnt = 0; pend_le = 0; pend_se = 0; pending = 0;
        st_en = 0; act_en = 0; staged = IDENT; active = IDENT;
        forever begin
            @(negedge clock);
            #2;
            e_tready = clock_en && (!synced || q.size() < 4);
            e_mvalid = clock_en && (q.size() != 0);
            e_update = e_mvalid && m_axis_tready && q[0].u && pending;
            check("m_s_tready", s_axis_tready, e_tready);
            check("m_m_tvalid", m_axis_tvalid, e_mvalid);
            if (e_mvalid) begin
                check("m_tdata", m_axis_tdata, q[0].d);
                check("m_tuser", m_axis_tuser, q[0].u);
                check("m_tlast", m_axis_tlast, q[0].l);
            end
            check("m_coeff_update", coeff_update, e_update);
            check("m_line_err", line_err, clock_en && pend_le);
            check("m_sof_err", sof_err, clock_en && pend_se);
            check("m_coeff_active", coeff_active, active);
            check("m_enable_active", enable_active, act_en);

            if (line_err) le_seen++;
            if (sof_err) se_seen++;
            if (coeff_update) upd_seen++;
            if (!reset && s_axis_tvalid && s_axis_tready) in_acc++;
            if (!reset && m_axis_tvalid && m_axis_tready) out_cnt++;

            if (reset) begin
                q.delete();
                synced = 0; line_cnt = 0; pend_le = 0; pend_se = 0; pending = 0;
                st_en = 0; act_en = 0; staged = IDENT; active = IDENT;
            end else if (clock_en) begin
                do_pop   = e_mvalid && m_axis_tready;
                do_write = s_axis_tvalid && e_tready && (synced || s_axis_tuser);
                pend_le  = 0;
                pend_se  = 0;
                if (do_write) begin
                    if (s_axis_tuser && line_cnt != 0) begin
                        pend_se  = 1;
                        line_cnt = 0;
                    end
                    if (line_cnt < 65535) line_cnt++;
                    if (s_axis_tlast) begin
                        pend_le  = (line_cnt != int'(cfg_line_beats));
                        line_cnt = 0;
                    end
                    synced = 1;
                end
                if (do_pop) begin
                    if (q[0].u && pending) begin
                        active  = staged;
                        act_en  = st_en;
                        pending = 0;
                    end
                    void'(q.pop_front());
                end
                if (cfg_commit) begin
                    staged  = cfg_coeff;
                    st_en   = cfg_enable;
                    pending = 1;
                end
                if (do_write) q.push_back(beat_t'({s_axis_tuser, s_axis_tlast, s_axis_tdata}));
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int     mark;
        coeff_t h13;
        reset = 1'b1; clock_en = 1'b1; m_axis_tready = 1'b1;
        s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tuser = 1'b0; s_axis_tlast = 1'b0;
        cfg_coeff = IDENT; cfg_enable = 1'b0; cfg_commit = 1'b0; cfg_line_beats = 16'd4;

        repeat (2) @(negedge clock);
        #1;
        check("rst_m_tvalid", m_axis_tvalid, 1'b0);
        check("rst_m_tdata", m_axis_tdata, 64'h0);
        check("rst_coeff_identity", coeff_active, IDENT);
        check("rst_enable", enable_active, 1'b0);
        check("rst_pulses", {coeff_update, line_err, sof_err}, 3'b000);
        @(negedge clock);
        reset = 1'b0;

        // Frame sync: three pre-SOF beats are dropped.
        send(64'h1, 1'b0, 1'b0);
        send(64'h2, 1'b0, 1'b0);
        send(64'h3, 1'b0, 1'b0);
        check("sync_drop_no_output", m_axis_tvalid, 1'b0);
        send(64'hA5, 1'b1, 1'b0);
        check("first_beat_valid", m_axis_tvalid, 1'b1);
        check("first_beat_tdata", m_axis_tdata, 64'hA5);
        check("first_beat_tuser", m_axis_tuser, 1'b1);
        check("ident_h11", coeff_active[31:0], 32'h00010000);
        check("ident_h22", coeff_active[159:128], 32'h00010000);

        // Lines of 4, 3 and 5 beats against an expected length of 4.
        send(64'h11, 1'b0, 1'b0); send(64'h12, 1'b0, 1'b0); send(64'h13, 1'b0, 1'b1);
        send(64'h21, 1'b0, 1'b0); send(64'h22, 1'b0, 1'b0); send(64'h23, 1'b0, 1'b1);
        send(64'h31, 1'b0, 1'b0); send(64'h32, 1'b0, 1'b0); send(64'h33, 1'b0, 1'b0);
        send(64'h34, 1'b0, 1'b0); send(64'h35, 1'b0, 1'b1);
        idle(3);
        check("line_err_count", le_seen, 2);
        check("beats_emitted", out_cnt, 12);

        // Backpressure: the FIFO takes four beats, then the fifth waits for space.
        @(negedge clock);
        m_axis_tready = 1'b0;
        mark = in_acc;
        send(64'h41, 1'b0, 1'b0); send(64'h42, 1'b0, 1'b0);
        send(64'h43, 1'b0, 1'b0); send(64'h44, 1'b0, 1'b1);
        check("full_accepted", in_acc - mark, 4);
        check("full_tready_low", s_axis_tready, 1'b0);
        check("full_head_tdata", m_axis_tdata, 64'h41);
        fork
            send(64'h45, 1'b0, 1'b0);
            begin
                repeat (3) @(negedge clock);
                m_axis_tready = 1'b1;
            end
        join
        send(64'h46, 1'b0, 1'b0);
        idle(6);
        check("bp_accepted_total", in_acc - mark, 6);

        // Two commits mid-frame; the later one must be applied at the next output SOF.
        commit(32'h00050000, 1'b1);
        #1;
        check("no_early_apply", coeff_active, IDENT);
        check("no_early_update", coeff_update, 1'b0);
        commit(32'h00070000, 1'b1);
        #1;
        check("still_identity", coeff_active, IDENT);

        // SOF after two beats of a line.
        send(64'h51, 1'b1, 1'b0);
        check("sof_err_pulse", sof_err, 1'b1);
        check("sof_fwd_tuser", m_axis_tuser, 1'b1);
        check("sof_fwd_tdata", m_axis_tdata, 64'h51);
        check("update_on_handshake", coeff_update, 1'b1);
        check("active_before_apply", coeff_active, IDENT);
        @(posedge clock);
        #1;
        h13 = coeff_t'(coeff_active[95:64]);
        check("h13_last_commit_wins", h13, 32'h00070000);
        check("enable_applied", enable_active, 1'b1);
        check("sof_err_one_cycle", sof_err, 1'b0);
        send(64'h52, 1'b0, 1'b0); send(64'h53, 1'b0, 1'b0); send(64'h54, 1'b0, 1'b1);
        idle(3);
        check("line_err_after_restart", le_seen, 2);
        check("sof_err_count", se_seen, 1);
        check("update_count", upd_seen, 1);

        // Stall with data buffered, then reset mid-frame.
        send(64'h61, 1'b0, 1'b0);
        @(negedge clock);
        m_axis_tready = 1'b0;
        send(64'h62, 1'b0, 1'b0);
        @(negedge clock);
        clock_en = 1'b0; m_axis_tready = 1'b1;
        s_axis_tdata = 64'h63; s_axis_tuser = 1'b0; s_axis_tlast = 1'b0; s_axis_tvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("stall_tready", s_axis_tready, 1'b0);
            check("stall_mvalid", m_axis_tvalid, 1'b0);
            @(negedge clock);
        end
        clock_en = 1'b1;
        s_axis_tvalid = 1'b0;
        #1;
        check("stall_kept_valid", m_axis_tvalid, 1'b1);
        check("stall_kept_head", m_axis_tdata, 64'h61);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("rst2_m_tvalid", m_axis_tvalid, 1'b0);
        check("rst2_sync_tready", s_axis_tready, 1'b1);
        check("rst2_coeff_identity", coeff_active, IDENT);
        check("rst2_enable", enable_active, 1'b0);
        send(64'h71, 1'b0, 1'b0);
        check("rst2_sync_drop", m_axis_tvalid, 1'b0);
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
